// File: rtl/step_driver_pkg.sv
// Shared types and defaults for the step_driver INC/DEC strobe front-end.
package step_driver_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLowUp,
    StLowDn,
    StRecover,
    StCompUp,
    StCompDn
  } state_e;

  localparam int unsigned DefPw   = 4;
  localparam int unsigned DefRw   = 2;
  localparam int unsigned DefSync = 2;

  // Strobes are active-low; this is their resting level.
  localparam logic StrobeIdle   = 1'b1;
  // CARRY_TOP/BORROW_TOP are active-low; synchronizers rest at this level.
  localparam logic FlagInactive = 1'b1;

endpackage

// File: rtl/step_driver_flag_sync.sv
// Multi-stage synchronizer for an active-low asynchronous flag; resets to the inactive level.
module flag_sync
  import step_driver_pkg::*;
#(
  parameter int unsigned SYNC = DefSync
) (
  input  logic CLK,
  input  logic CLR,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC-1:0] sync_q, sync_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d_i;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync_q <= {SYNC{FlagInactive}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC-1];

endmodule

// File: rtl/step_driver.sv
// Shapes user/countdown requests into exclusive active-low INC/DEC pulses for the counter chain,
// compensating wrap-around at zero (underflow) and at the chain maximum (overflow).
module step_driver
  import step_driver_pkg::*;
#(
  parameter int unsigned PW   = DefPw,
  parameter int unsigned RW   = DefRw,
  parameter int unsigned SYNC = DefSync
) (
  input  logic CLK,
  input  logic CLR,
  input  logic RUN,
  input  logic TICK,
  input  logic UP_REQ,
  input  logic DN_REQ,
  input  logic CARRY_TOP,
  input  logic BORROW_TOP,
  output logic INC,
  output logic DEC,
  output logic BUSY,
  output logic DONE,
  output logic SAT
);

  localparam int unsigned CntMax = (PW > RW) ? PW : RW;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] PwLast = CntW'(PW - 1);
  localparam logic [CntW-1:0] RwLast = CntW'(RW - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_up_q, pend_up_d;
  logic            pend_dn_q, pend_dn_d;
  logic            pend_tick_q, pend_tick_d;
  logic            comp_up_q, comp_up_d;
  logic            comp_dn_q, comp_dn_d;
  logic            done_q, done_d;
  logic            sat_q, sat_d;
  logic            inc_q, inc_d;
  logic            dec_q, dec_d;

  logic carry_s, borrow_s;
  logic cancel, launch_up, launch_dn, launch_tick;

  flag_sync #(.SYNC(SYNC)) u_carry_sync (
    .CLK (CLK),
    .CLR (CLR),
    .d_i (CARRY_TOP),
    .q_o (carry_s)
  );

  flag_sync #(.SYNC(SYNC)) u_borrow_sync (
    .CLK (CLK),
    .CLR (CLR),
    .d_i (BORROW_TOP),
    .q_o (borrow_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    comp_up_d   = comp_up_q;
    comp_dn_d   = comp_dn_q;
    done_d      = done_q;
    sat_d       = sat_q;
    launch_up   = 1'b0;
    launch_dn   = 1'b0;
    launch_tick = 1'b0;
    // Opposing user requests annihilate, whatever the FSM is doing.
    cancel      = pend_up_q & pend_dn_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pend_up_q && !pend_dn_q) begin
          launch_up = 1'b1;
          state_d   = StLowUp;
          done_d    = 1'b0;
        end else if (pend_dn_q && !pend_up_q) begin
          launch_dn = 1'b1;
          state_d   = StLowDn;
          sat_d     = 1'b0;
        end else if (pend_tick_q) begin
          launch_tick = 1'b1;
          state_d     = StLowDn;
          sat_d       = 1'b0;
        end
      end
      StLowUp, StLowDn, StCompUp, StCompDn: begin
        if (cnt_q == PwLast) begin
          cnt_d   = '0;
          state_d = StRecover;
          // Flags are valid by now: SYNC+1 cycles have elapsed since the strobe fell.
          if (state_q == StLowUp && !carry_s) comp_dn_d = 1'b1;
          if (state_q == StLowDn && !borrow_s) comp_up_d = 1'b1;
        end
      end
      StRecover: begin
        if (cnt_q == RwLast) begin
          cnt_d = '0;
          if (comp_up_q) begin
            state_d   = StCompUp;
            comp_up_d = 1'b0;
            done_d    = 1'b1;
          end else if (comp_dn_q) begin
            state_d   = StCompDn;
            comp_dn_d = 1'b0;
            sat_d     = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    pend_up_d   = (pend_up_q & ~cancel & ~launch_up) | UP_REQ;
    pend_dn_d   = (pend_dn_q & ~cancel & ~launch_dn) | DN_REQ;
    pend_tick_d = (pend_tick_q & ~launch_tick) | (TICK & RUN & ~done_q);

    inc_d = (state_d == StLowUp || state_d == StCompUp) ? ~StrobeIdle : StrobeIdle;
    dec_d = (state_d == StLowDn || state_d == StCompDn) ? ~StrobeIdle : StrobeIdle;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_up_q   <= 1'b0;
      pend_dn_q   <= 1'b0;
      pend_tick_q <= 1'b0;
      comp_up_q   <= 1'b0;
      comp_dn_q   <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      inc_q       <= StrobeIdle;
      dec_q       <= StrobeIdle;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_up_q   <= pend_up_d;
      pend_dn_q   <= pend_dn_d;
      pend_tick_q <= pend_tick_d;
      comp_up_q   <= comp_up_d;
      comp_dn_q   <= comp_dn_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
    end
  end

  assign INC  = inc_q;
  assign DEC  = dec_q;
  assign BUSY = (state_q != StIdle);
  assign DONE = done_q;
  assign SAT  = sat_q;

endmodule
